uart_rx_frame: RTL and testbench

//   UART receiver: 8 data bits, LSB first, 1 start bit, 1 stop bit, no parity.

---
 rtl/uart_rx_frame.sv | 137 +++++++++++++
 tb/tb_uart_rx_frame.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// UART receiver, 8N1, LSB first: 2-flop synchroniser, mid-bit start validation and
// mid-bit sampling, one-cycle data-valid or framing-error strobe per frame.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line idle, waiting for rx_s low
// START   | counting to mid start bit, rejecting glitches
// DATA    | sampling 8 data bits at mid-bit, LSB first
// STOP    | sampling the stop bit at mid-bit
// CLEANUP | one cycle after a good byte, strobe drops
// BREAK   | stop bit was low, wait for the line to return high
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Active
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4,
        BREAK   = 3'd5
    } state_t;

    localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic [15:0] count;
    logic [2:0]  idx;
    logic [7:0]  shift;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state          <= IDLE;
            count          <= 16'd0;
            idx            <= 3'd0;
            shift          <= 8'h00;
            o_Rx_DV        <= 1'b0;
            o_Rx_Byte      <= 8'h00;
            o_Rx_Frame_Err <= 1'b0;
            o_Rx_Active    <= 1'b0;
        end else begin
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
            case (state)
                IDLE: begin
                    count <= 16'd0;
                    idx   <= 3'd0;
                    if (!rx_s) begin
                        state       <= START;
                        o_Rx_Active <= 1'b1;
                    end
                end
                START: begin
                    if (count == HALF) begin
                        count <= 16'd0;
                        if (rx_s) begin
                            state       <= IDLE;
                            o_Rx_Active <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                DATA: begin
                    if (count == LAST) begin
                        count      <= 16'd0;
                        shift[idx] <= rx_s;
                        if (idx == 3'd7) begin
                            idx   <= 3'd0;
                            state <= STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                STOP: begin
                    if (count == LAST) begin
                        count       <= 16'd0;
                        o_Rx_Active <= 1'b0;
                        if (rx_s) begin
                            o_Rx_Byte <= shift;
                            o_Rx_DV   <= 1'b1;
                            state     <= CLEANUP;
                        end else begin
                            // byte is discarded; BREAK holds off new starts while low
                            o_Rx_Frame_Err <= 1'b1;
                            state          <= BREAK;
                        end
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                CLEANUP: begin
                    state <= IDLE;
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    count       <= 16'd0;
                    idx         <= 3'd0;
                    o_Rx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: a serial-line transmitter model drives two receivers
// (8 and 87 clocks per bit); expected bytes/errors are queued and matched on strobes.
`timescale 1ns/1ps
module tb_uart_rx_frame;

    localparam int C8  = 8;
    localparam int H8  = (C8 - 1) / 2;
    localparam real BIT8  = 80.0;
    localparam real BIT87 = 870.0;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx8   = 1'b1;
    logic       rx87  = 1'b1;
    logic       dv8, fe8, act8, dv87, fe87, act87;
    logic [7:0] byte8, byte87;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // expected events: bit 8 set = framing error, else {0, byte}
    logic [8:0] q8[$];
    logic [8:0] q87[$];
    int dv8_n = 0, fe8_n = 0, act8_n = 0, last_dv8 = 0;
    int dv87_n = 0, fe87_n = 0;

    uart_rx_frame #(.CLKS_PER_BIT(8)) dut8 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx8),
        .o_Rx_DV(dv8), .o_Rx_Byte(byte8), .o_Rx_Frame_Err(fe8), .o_Rx_Active(act8)
    );

    uart_rx_frame #(.CLKS_PER_BIT(87)) dut87 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx87),
        .o_Rx_DV(dv87), .o_Rx_Byte(byte87), .o_Rx_Frame_Err(fe87), .o_Rx_Active(act87)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin : mon8
        logic       prev_dv, prev_fe;
        logic [8:0] e;
        prev_dv = 1'b0;
        prev_fe = 1'b0;
        forever begin
            @(negedge clk);
            if (dv8) begin
                chk("dv8_fe_excl", fe8, 0);
                chk("dv8_active", act8, 0);
                chk("dv8_width", prev_dv, 0);
                chk("dv8_pending", q8.size() > 0, 1);
                if (q8.size() > 0) begin
                    e = q8.pop_front();
                    chk("dv8_byte", {1'b0, byte8}, e);
                end
                dv8_n++;
                last_dv8 = cyc;
            end
            if (fe8) begin
                chk("fe8_width", prev_fe, 0);
                chk("fe8_pending", q8.size() > 0, 1);
                if (q8.size() > 0) begin
                    e = q8.pop_front();
                    chk("fe8_kind", e[8], 1);
                end
                fe8_n++;
            end
            if (act8) act8_n++;
            prev_dv = dv8;
            prev_fe = fe8;
        end
    end

    initial begin : mon87
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (dv87) begin
                chk("dv87_fe_excl", fe87, 0);
                chk("dv87_pending", q87.size() > 0, 1);
                if (q87.size() > 0) begin
                    e = q87.pop_front();
                    chk("dv87_byte", {1'b0, byte87}, e);
                end
                dv87_n++;
            end
            if (fe87) fe87_n++;
        end
    end

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx8 = v;
        else          rx87 = v;
    endtask

    // one 8N1 frame; the line is left at the stop-bit level
    task automatic send(input int sel, input logic [7:0] b, input realtime bt, input logic stop);
        drive(sel, 1'b0);
        #(bt);
        for (int i = 0; i < 8; i++) begin
            drive(sel, b[i]);
            #(bt);
        end
        drive(sel, stop);
        #(bt);
    endtask

    function automatic realtime skewed(input realtime nominal, input int permil);
        return nominal * (1000.0 + real'(permil)) / 1000.0;
    endfunction

    task automatic drain8();
        for (int i = 0; i < 400 && q8.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("drain8", q8.size(), 0);
    endtask

    task automatic drain87();
        for (int i = 0; i < 2000 && q87.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("drain87", q87.size(), 0);
    endtask

    initial begin : main
        int d0, f0, e0, a0, skew;
        logic [7:0] b, mask;
        logic [7:0] edge_bytes[4];
        logic [7:0] c3;

        rst_n = 1'b0;
        #1;
        chk("rst_dv8", dv8, 0);
        chk("rst_byte8", byte8, 8'h00);
        chk("rst_fe8", fe8, 0);
        chk("rst_act8", act8, 0);
        chk("rst_dv87", dv87, 0);
        chk("rst_byte87", byte87, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 1: exact-timing frame, strobe latency and active window
        q8.push_back({1'b0, 8'h37});
        e0 = cyc;
        a0 = act8_n;
        send(0, 8'h37, BIT8, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("t1_dv_count", dv8_n, 1);
        chk("t1_fe_count", fe8_n, 0);
        chk("t1_byte", byte8, 8'h37);
        chk("t1_latency", last_dv8 - e0, 3 + H8 + 9 * C8 + 1);
        chk("t1_active_cycles", act8_n - a0, H8 + 9 * C8 + 1);
        chk("t1_active_end", act8, 0);

        // 2: 3-cycle low glitch rejected, then a normal frame
        rx8 = 1'b0;
        #30;
        rx8 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t2_glitch_dv", dv8_n, 1);
        chk("t2_glitch_fe", fe8_n, 0);
        chk("t2_glitch_active", act8, 0);
        q8.push_back({1'b0, 8'hA5});
        send(0, 8'hA5, BIT8, 1'b1);
        drain8();
        chk("t2_byte", byte8, 8'hA5);
        chk("t2_dv_count", dv8_n, 2);

        // 3: low stop bit followed by a held-low line
        q8.push_back(9'h100);
        send(0, 8'h5A, BIT8, 1'b0);
        #400;
        chk("t3_fe_count", fe8_n, 1);
        chk("t3_dv_count", dv8_n, 2);
        chk("t3_byte_kept", byte8, 8'hA5);
        chk("t3_break_active", act8, 0);
        rx8 = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("t3_fe_after", fe8_n, 1);
        chk("t3_dv_after", dv8_n, 2);
        chk("t3_queue", q8.size(), 0);

        // 4: zero-gap frames, then random bytes with random gaps and skew
        d0 = dv8_n;
        edge_bytes = '{8'h00, 8'hFF, 8'h80, 8'h01};
        foreach (edge_bytes[i]) begin
            q8.push_back({1'b0, edge_bytes[i]});
            send(0, edge_bytes[i], BIT8, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            skew = int'($urandom_range(0, 60)) - 30;
            q8.push_back({1'b0, b});
            send(0, b, skewed(BIT8, skew), 1'b1);
            #($urandom_range(0, 30) * 10);
        end
        drain8();
        chk("t4_dv_count", dv8_n - d0, 12);
        chk("t4_fe_count", fe8_n, 1);

        // 5: reset mid bit 4; the transmitter shares the reset so the line idles
        @(posedge clk);
        #1;
        d0 = dv8_n;
        f0 = fe8_n;
        c3 = 8'hC3;
        rx8 = 1'b0;
        #(BIT8);
        for (int i = 0; i < 4; i++) begin
            rx8 = c3[i];
            #(BIT8);
        end
        rx8 = c3[4];
        #(BIT8 / 2.0);
        chk("t5_active_pre", act8, 1);
        rst_n = 1'b0;
        rx8 = 1'b1;
        #1;
        chk("t5_rst_dv", dv8, 0);
        chk("t5_rst_byte", byte8, 8'h00);
        chk("t5_rst_fe", fe8, 0);
        chk("t5_rst_active", act8, 0);
        #9;
        rst_n = 1'b1;
        repeat (120) @(posedge clk);
        #1;
        chk("t5_no_dv", dv8_n, d0);
        chk("t5_no_fe", fe8_n, f0);
        q8.push_back({1'b0, 8'h3C});
        send(0, 8'h3C, BIT8, 1'b1);
        drain8();
        chk("t5_byte", byte8, 8'h3C);
        chk("t5_dv_count", dv8_n, d0 + 1);

        // 6a: every byte value at 8 clocks/bit with +/-3% skew, mostly zero gap
        d0 = dv8_n;
        f0 = fe8_n;
        mask = 8'($urandom_range(0, 255));
        for (int v = 0; v < 256; v++) begin
            b = 8'(v) ^ mask;
            skew = (v % 3 == 0) ? -30 : (v % 3 == 1) ? 30 : int'($urandom_range(0, 60)) - 30;
            q8.push_back({1'b0, b});
            send(0, b, skewed(BIT8, skew), 1'b1);
            if ($urandom_range(0, 7) == 0) #($urandom_range(1, 200));
        end
        drain8();
        chk("t6a_dv_count", dv8_n - d0, 256);
        chk("t6a_fe_count", fe8_n, f0);

        // 6b: 87 clocks/bit with +/-3% skew
        for (int i = 0; i < 40; i++) begin
            b = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'($urandom_range(0, 255));
            skew = (i % 3 == 0) ? -30 : (i % 3 == 1) ? 30 : int'($urandom_range(0, 60)) - 30;
            q87.push_back({1'b0, b});
            send(1, b, skewed(BIT87, skew), 1'b1);
            if ($urandom_range(0, 3) == 0) #($urandom_range(1, 2000));
        end
        drain87();
        chk("t6b_dv_count", dv87_n, 40);
        chk("t6b_fe_count", fe87_n, 0);
        chk("t6b_active_end", act87, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
